// File: rtl/impulse_sequencer_if.sv
// Capture, memory and tap-stream signals of the impulse sequencer.
// slave faces the sequencer, master faces its environment.
interface impulse_sequencer_if #(
  parameter int DATA_WIDTH = 1024
);
  logic                  sample_tick;
  logic                  cap_start;
  logic                  cap_valid;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  cap_ready;
  logic                  cap_done;
  logic [15:0]           mem_write_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write_enable;
  logic [15:0]           mem_read_addr;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  tap_valid;
  logic [15:0]           tap_index;
  logic [DATA_WIDTH-1:0] tap_data;
  logic                  tap_last;
  logic                  sweep_busy;
  logic                  overrun;

  modport slave (
    input  sample_tick,
    input  cap_start,
    input  cap_valid,
    input  cap_data,
    output cap_ready,
    output cap_done,
    output mem_write_addr,
    output mem_write_data,
    output mem_write_enable,
    output mem_read_addr,
    input  mem_read_data,
    output tap_valid,
    output tap_index,
    output tap_data,
    output tap_last,
    output sweep_busy,
    output overrun
  );

  modport master (
    output sample_tick,
    output cap_start,
    output cap_valid,
    output cap_data,
    input  cap_ready,
    input  cap_done,
    input  mem_write_addr,
    input  mem_write_data,
    input  mem_write_enable,
    input  mem_read_addr,
    output mem_read_data,
    input  tap_valid,
    input  tap_index,
    input  tap_data,
    input  tap_last,
    input  sweep_busy,
    input  overrun
  );
endinterface

// File: rtl/impulse_sequencer.sv
// Captures an impulse response into external memory and replays it
// as an indexed tap stream once per audio sample.
module impulse_sequencer #(
  parameter int IMPULSE_LENGTH = 750,
  parameter int DATA_WIDTH     = 1024,
  parameter int READ_LATENCY   = 2
) (
  input  logic               audio_clk,
  input  logic               rst_in,
  impulse_sequencer_if.slave bus
);
  localparam logic [15:0] LAST = 16'(IMPULSE_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SWEEP
  } state_e;

  state_e      state_q, state_d;
  logic        loaded_q, loaded_d;
  logic        pend_q, pend_d;
  logic [15:0] wptr_q, wptr_d;
  logic [15:0] rptr_q, rptr_d;
  logic        issued_q, issued_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;

  logic [READ_LATENCY-1:0] vld_q;
  logic [15:0]             idx_q [READ_LATENCY];

  logic issue;
  logic wr_en;
  logic tap_v;
  logic tap_l;

  assign issue = (state_q == SWEEP) && !issued_q;
  assign wr_en = (state_q == CAPTURE) && bus.cap_valid;
  assign tap_v = vld_q[READ_LATENCY-1];
  assign tap_l = tap_v && (idx_q[READ_LATENCY-1] == LAST);

  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    pend_d   = pend_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    ovr_d    = bus.sample_tick && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (bus.cap_start || pend_q) begin
          state_d = CAPTURE;
          wptr_d  = '0;
          pend_d  = 1'b0;
        end else if (bus.sample_tick && loaded_q) begin
          state_d  = SWEEP;
          rptr_d   = '0;
          issued_d = 1'b0;
        end
      end
      CAPTURE: begin
        if (wr_en) begin
          if (wptr_q == LAST) begin
            loaded_d = 1'b1;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            wptr_d = wptr_q + 16'd1;
          end
        end
      end
      SWEEP: begin
        if (bus.cap_start) pend_d = 1'b1;
        if (issue) begin
          if (rptr_q == LAST) issued_d = 1'b1;
          else rptr_d = rptr_q + 16'd1;
        end
        // A pending capture starts straight after the final tap
        if (tap_l) begin
          if (pend_d) begin
            state_d = CAPTURE;
            wptr_d  = '0;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge audio_clk) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      loaded_q <= 1'b0;
      pend_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      issued_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      vld_q    <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        idx_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      pend_q   <= pend_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      issued_q <= issued_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      vld_q[0] <= issue;
      idx_q[0] <= rptr_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign bus.cap_ready        = (state_q == CAPTURE);
  assign bus.cap_done         = done_q;
  assign bus.mem_write_enable = wr_en;
  assign bus.mem_write_addr   =
    (state_q == CAPTURE) ? wptr_q : 16'd0;
  assign bus.mem_write_data   =
    (state_q == CAPTURE) ? bus.cap_data : {DATA_WIDTH{1'b0}};
  assign bus.mem_read_addr    = issue ? rptr_q : 16'd0;
  assign bus.tap_valid        = tap_v;
  assign bus.tap_index        =
    tap_v ? idx_q[READ_LATENCY-1] : 16'd0;
  assign bus.tap_data         =
    tap_v ? bus.mem_read_data : {DATA_WIDTH{1'b0}};
  assign bus.tap_last         = tap_l;
  assign bus.sweep_busy       = (state_q == SWEEP);
  assign bus.overrun          = ovr_q;
endmodule

// File: tb/tb_impulse_sequencer.sv
// Scoreboard bench for impulse_sequencer with an 8-tap impulse and a
// two-cycle memory model.
module tb_impulse_sequencer;
  localparam int L  = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic [15:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [15:0]   idx;
    logic [DW-1:0] data;
    logic          last;
  } tap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  impulse_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  impulse_sequencer #(
    .IMPULSE_LENGTH(L),
    .DATA_WIDTH(DW),
    .READ_LATENCY(2)
  ) dut (
    .audio_clk(clk),
    .rst_in(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [L];
  logic [DW-1:0] rd1, rd2;

  always_ff @(posedge clk) begin
    if (bus.mem_write_enable)
      mem[bus.mem_write_addr[2:0]] <= bus.mem_write_data;
    rd1 <= mem[bus.mem_read_addr[2:0]];
    rd2 <= rd1;
  end

  assign bus.mem_read_data = rd2;

  wr_t  exp_wr_q  [$];
  tap_t exp_tap_q [$];
  int   exp_done_q[$];
  int   exp_ovr_q [$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_total = 0;
  wr_t  mw;
  tap_t mt;
  int   b0;
  int   w;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cap_ready"}, 64'(bus.cap_ready), 0);
    check({tag, "_cap_done"}, 64'(bus.cap_done), 0);
    check({tag, "_wr_en"}, 64'(bus.mem_write_enable), 0);
    check({tag, "_wr_addr"}, 64'(bus.mem_write_addr), 0);
    check({tag, "_wr_data"}, 64'(bus.mem_write_data), 0);
    check({tag, "_rd_addr"}, 64'(bus.mem_read_addr), 0);
    check({tag, "_tap_valid"}, 64'(bus.tap_valid), 0);
    check({tag, "_tap_index"}, 64'(bus.tap_index), 0);
    check({tag, "_tap_data"}, 64'(bus.tap_data), 0);
    check({tag, "_tap_last"}, 64'(bus.tap_last), 0);
    check({tag, "_busy"}, 64'(bus.sweep_busy), 0);
    check({tag, "_overrun"}, 64'(bus.overrun), 0);
  endtask

  task automatic beat(input logic [DW-1:0] d,
                      input logic [15:0] a);
    int n = 0;
    exp_wr_q.push_back('{a, d});
    bus.cap_valid = 1'b1;
    bus.cap_data  = d;
    while (!bus.cap_ready && n < 20) begin
      cyc();
      n++;
    end
    check("beat_ready", 64'(bus.cap_ready), 1);
    cyc();
    bus.cap_valid = 1'b0;
  endtask

  task automatic capture(input logic [DW-1:0] base,
                         input bit start,
                         input bit tick_mid);
    if (start) begin
      bus.cap_start = 1'b1;
      cyc();
      bus.cap_start = 1'b0;
    end
    for (int k = 0; k < L; k++) begin
      beat(base + DW'(k), 16'(k));
      if (k == L - 1) begin
        exp_done_q.push_back(1);
        check("cap_ready_after", 64'(bus.cap_ready), 0);
      end else if (k % 2 == 1) begin
        if (tick_mid && k == 3) begin
          bus.sample_tick = 1'b1;
          exp_ovr_q.push_back(1);
        end
        cyc();
        bus.sample_tick = 1'b0;
      end
    end
    cyc();
  endtask

  task automatic run_sweep(input logic [DW-1:0] base,
                           input int tick_at,
                           input int cap_at,
                           input bit exp_cap);
    int n = 0;
    int bs = busy_total;
    for (int i = 0; i < L; i++)
      exp_tap_q.push_back('{16'(i), base + DW'(i), i == L - 1});
    bus.sample_tick = 1'b1;
    cyc();
    for (int i = 0; i < L; i++) begin
      bus.sample_tick = (i == tick_at);
      bus.cap_start   = (i == cap_at);
      if (i == tick_at) exp_ovr_q.push_back(1);
      check("rd_addr", 64'(bus.mem_read_addr), 64'(i));
      if (i == 1)
        check("tap_early", 64'(bus.tap_valid), 0);
      if (i == 2) begin
        check("tap_first", 64'(bus.tap_valid), 1);
        check("tap_first_idx", 64'(bus.tap_index), 0);
      end
      cyc();
    end
    bus.sample_tick = 1'b0;
    bus.cap_start   = 1'b0;
    while (!bus.tap_last && n < 10) begin
      cyc();
      n++;
    end
    check("tap_last_seen", 64'(bus.tap_last), 1);
    cyc();
    check("busy_end", 64'(bus.sweep_busy), 0);
    check("busy_cycles", 64'(busy_total - bs), 10);
    check("cap_after_sweep", 64'(bus.cap_ready), 64'(exp_cap));
  endtask

  initial begin
    bus.sample_tick = 1'b0;
    bus.cap_start   = 1'b0;
    bus.cap_valid   = 1'b0;
    bus.cap_data    = '0;

    fork
      forever begin
        @(negedge clk);
        if (bus.sweep_busy) busy_total++;
        if (bus.mem_write_enable) begin
          if (exp_wr_q.size() == 0) begin
            check("unexp_write", 64'(bus.mem_write_addr), 64'hffff);
          end else begin
            mw = exp_wr_q.pop_front();
            check("wr_addr", 64'(bus.mem_write_addr), 64'(mw.addr));
            check("wr_data", 64'(bus.mem_write_data), 64'(mw.data));
          end
        end
        if (bus.tap_valid) begin
          if (exp_tap_q.size() == 0) begin
            check("unexp_tap", 64'(bus.tap_index), 64'hffff);
          end else begin
            mt = exp_tap_q.pop_front();
            check("tap_index", 64'(bus.tap_index), 64'(mt.idx));
            check("tap_data", 64'(bus.tap_data), 64'(mt.data));
            check("tap_last", 64'(bus.tap_last), 64'(mt.last));
          end
        end
        if (bus.cap_done) begin
          if (exp_done_q.size() == 0)
            check("unexp_cap_done", 64'(bus.cap_done), 0);
          else
            void'(exp_done_q.pop_front());
        end
        if (bus.overrun) begin
          if (exp_ovr_q.size() == 0)
            check("unexp_overrun", 64'(bus.overrun), 0);
          else
            void'(exp_ovr_q.pop_front());
        end
      end
    join_none

    repeat (3) cyc();
    check_zero("reset");
    rst_n = 1'b1;
    cyc();

    // tick before any capture is ignored
    b0 = busy_total;
    bus.sample_tick = 1'b1;
    cyc();
    bus.sample_tick = 1'b0;
    repeat (5) cyc();
    check("unloaded_busy", 64'(busy_total - b0), 0);

    capture(32'h10, 1'b1, 1'b1);
    check("done_q_empty1", 64'(exp_done_q.size()), 0);

    run_sweep(32'h10, 4, -1, 1'b0);

    // capture wins over a simultaneous tick
    bus.cap_start   = 1'b1;
    bus.sample_tick = 1'b1;
    cyc();
    bus.cap_start   = 1'b0;
    bus.sample_tick = 1'b0;
    check("prio_cap_ready", 64'(bus.cap_ready), 1);
    check("prio_busy", 64'(bus.sweep_busy), 0);
    capture(32'h20, 1'b0, 1'b0);

    run_sweep(32'h20, -1, 2, 1'b1);
    capture(32'h30, 1'b0, 1'b0);

    // reset in the middle of a sweep
    for (int i = 0; i < L; i++)
      exp_tap_q.push_back('{16'(i), 32'h30 + DW'(i), i == L - 1});
    bus.sample_tick = 1'b1;
    cyc();
    bus.sample_tick = 1'b0;
    w = 0;
    while (!(bus.tap_valid && bus.tap_index == 16'd3) && w < 20) begin
      cyc();
      w++;
    end
    check("rst_tap3_seen", 64'(bus.tap_index), 3);
    rst_n = 1'b0;
    cyc();
    exp_tap_q.delete();
    check_zero("midrst");
    rst_n = 1'b1;
    cyc();
    b0 = busy_total;
    bus.sample_tick = 1'b1;
    cyc();
    bus.sample_tick = 1'b0;
    repeat (12) cyc();
    check("post_rst_busy", 64'(busy_total - b0), 0);

    repeat (3) cyc();
    check("wr_q_empty", 64'(exp_wr_q.size()), 0);
    check("tap_q_empty", 64'(exp_tap_q.size()), 0);
    check("done_q_empty", 64'(exp_done_q.size()), 0);
    check("ovr_q_empty", 64'(exp_ovr_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
